// File: rtl/ebi_master.sv
// ebi_master: single-word initiator for the 16-bit external bus, with programmable setup/strobe/hold timing.
// Optional feature: define EBI_MASTER_WAIT_EN to add the ebi_wait input and strobe extension with timeout.
module ebi_master #(
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned WAIT_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ebi_addr,
    inout  logic [DATA_W-1:0] ebi_data,
    output logic              ebi_cs,
    output logic              ebi_rd,
    output logic              ebi_wr
`ifdef EBI_MASTER_WAIT_EN
    ,
    input  logic              ebi_wait
`endif
);

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES);
    localparam logic [7:0] WAIT_LIMIT  = 8'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;

    logic              wait_in;
    logic              phase_last;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_data;

    // Without the wait port the extension path sees a constant 0 and folds away.
`ifdef EBI_MASTER_WAIT_EN
    assign wait_in = ebi_wait;
`else
    assign wait_in = 1'b0;
`endif

    assign phase_last = (cnt_q == 8'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cap_d       = cap_q;
        timeout_d   = timeout_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;
        done_data   = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_last) begin
                    cnt_d   = STROBE_LOAD;
                    wcnt_d  = '0;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (!phase_last) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (wait_in && (wcnt_q != WAIT_LIMIT)) begin
                    wcnt_d = wcnt_q + 8'd1;
                end else begin
                    // Capture here; with no hold phase the sample goes straight to the response.
                    cap_d     = wait_in ? '0 : ebi_data;
                    timeout_d = wait_in;
                    if (HOLD_CYCLES == 0) begin
                        done      = 1'b1;
                        done_err  = wait_in;
                        done_data = wait_in ? '0 : ebi_data;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (phase_last) begin
                    done      = 1'b1;
                    done_err  = timeout_q;
                    done_data = cap_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase

        if (done) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = done_err;
            rdata_d     = we_q ? '0 : done_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            timeout_q   <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cap_q       <= cap_d;
            timeout_q   <= timeout_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ebi_addr  = addr_q;
    assign ebi_cs    = (state_q != IDLE);
    assign ebi_rd    = (state_q == STROBE) && !we_q;
    assign ebi_wr    = (state_q == STROBE) && we_q;
    assign ebi_data  = (we_q && (state_q != IDLE)) ? wdata_q : 'z;

endmodule

// File: tb/tb_ebi_master.sv
// Directed self-checking bench for ebi_master: default timing instance (a) and 1/1/0 timing instance (b).
module tb_ebi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Instance a: default timing, WAIT_TIMEOUT=3
    logic        a_req_valid, a_req_we, a_req_ready;
    logic [18:0] a_req_addr, a_addr;
    logic [15:0] a_req_wdata, a_rsp_rdata, a_rv;
    logic        a_rsp_valid, a_rsp_err, a_cs, a_rd, a_wr, a_probe;
    wire  [15:0] a_data;
`ifdef EBI_MASTER_WAIT_EN
    logic        a_wait;
`endif

    // Responder answers reads; probe drives 0 where the master must be silent.
    assign a_data = (a_cs && a_rd) ? a_rv : (a_probe ? 16'h0000 : 16'hzzzz);

    // Instance b: SETUP=1, STROBE=1, HOLD=0
    logic        b_req_valid, b_req_we, b_req_ready;
    logic [18:0] b_req_addr, b_addr;
    logic [15:0] b_req_wdata, b_rsp_rdata, b_rv;
    logic        b_rsp_valid, b_rsp_err, b_cs, b_rd, b_wr, b_probe;
    wire  [15:0] b_data;

    assign b_data = (b_cs && b_rd) ? b_rv : (b_probe ? 16'h0000 : 16'hzzzz);

    ebi_master #(
        .ADDR_W(19), .DATA_W(16), .SETUP_CYCLES(2), .STROBE_CYCLES(4),
        .HOLD_CYCLES(1), .WAIT_TIMEOUT(3)
    ) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .ebi_addr(a_addr), .ebi_data(a_data),
        .ebi_cs(a_cs), .ebi_rd(a_rd), .ebi_wr(a_wr)
`ifdef EBI_MASTER_WAIT_EN
        ,
        .ebi_wait(a_wait)
`endif
    );

    ebi_master #(
        .ADDR_W(19), .DATA_W(16), .SETUP_CYCLES(1), .STROBE_CYCLES(1),
        .HOLD_CYCLES(0), .WAIT_TIMEOUT(3)
    ) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .ebi_addr(b_addr), .ebi_data(b_data),
        .ebi_cs(b_cs), .ebi_rd(b_rd), .ebi_wr(b_wr)
`ifdef EBI_MASTER_WAIT_EN
        ,
        .ebi_wait(1'b0)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_probe = 1'b1;
        b_probe = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset a_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset a_rsp_valid got=%b exp=0", a_rsp_valid); end
        checks++; if (a_rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset a_rsp_rdata got=%h exp=0000", a_rsp_rdata); end
        checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL reset a_rsp_err got=%b exp=0", a_rsp_err); end
        checks++; if (a_addr !== 19'h0) begin errors++; $display("FAIL reset a_addr got=%h exp=0", a_addr); end
        checks++; if ({a_cs, a_rd, a_wr} !== 3'b000) begin errors++; $display("FAIL reset a_strobes got=%b exp=000", {a_cs, a_rd, a_wr}); end
        checks++; if (a_data !== 16'h0000) begin errors++; $display("FAIL reset a_bus_released got=%h exp=0000", a_data); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL reset b_req_ready got=%b exp=1", b_req_ready); end
        checks++; if ({b_cs, b_rd, b_wr, b_rsp_valid} !== 4'b0000) begin errors++; $display("FAIL reset b_outputs got=%b exp=0000", {b_cs, b_rd, b_wr, b_rsp_valid}); end
        reset = 1'b0;
        tick();
    endtask

    // One transaction on instance a; n_wait = wait pulses in the last strobe cycle, stuck = wait never drops.
    task automatic txn_a(input string name, input logic we, input logic [18:0] addr,
                         input logic [15:0] wd, input logic [15:0] rv,
                         input int n_wait, input logic stuck);
        int          ext, hold_c, rsp_c;
        logic [15:0] exp_rdata;
        ext       = stuck ? 3 : n_wait;
        hold_c    = 7 + ext;
        rsp_c     = 8 + ext;
        exp_rdata = (we || stuck) ? 16'h0 : rv;
        a_rv        = rv;
        a_probe     = !we;
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = we ? wd : 16'hFFFF;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready got=%b exp=1", name, a_req_ready); end
        tick();
        a_req_valid = 1'b0;
        a_req_we    = ~we;
        a_req_addr  = ~addr;
        a_req_wdata = ~wd;
        for (int c = 1; c <= rsp_c; c++) begin
            logic        e_cs, e_str;
            logic [15:0] e_bus;
            e_cs  = (c <= hold_c);
            e_str = (c >= 3) && (c <= 6 + ext);
            a_probe = !(we && e_cs);
`ifdef EBI_MASTER_WAIT_EN
            a_wait = stuck ? ((c >= 3) && (c <= 6 + ext)) : ((c >= 6) && (c < 6 + n_wait));
`endif
            #1;
            e_bus = (we && e_cs) ? wd : ((!we && e_str) ? rv : 16'h0000);
            checks++; if (a_cs !== e_cs) begin errors++; $display("FAIL %s c%0d cs got=%b exp=%b", name, c, a_cs, e_cs); end
            checks++; if (a_rd !== (!we && e_str)) begin errors++; $display("FAIL %s c%0d rd got=%b exp=%b", name, c, a_rd, !we && e_str); end
            checks++; if (a_wr !== (we && e_str)) begin errors++; $display("FAIL %s c%0d wr got=%b exp=%b", name, c, a_wr, we && e_str); end
            checks++; if (a_data !== e_bus) begin errors++; $display("FAIL %s c%0d bus got=%h exp=%h", name, c, a_data, e_bus); end
            checks++; if (a_req_ready !== !e_cs) begin errors++; $display("FAIL %s c%0d req_ready got=%b exp=%b", name, c, a_req_ready, !e_cs); end
            checks++; if (a_rsp_valid !== (c == rsp_c)) begin errors++; $display("FAIL %s c%0d rsp_valid got=%b exp=%b", name, c, a_rsp_valid, c == rsp_c); end
            if (e_cs) begin
                checks++; if (a_addr !== addr) begin errors++; $display("FAIL %s c%0d addr got=%h exp=%h", name, c, a_addr, addr); end
            end
            if (c == rsp_c) begin
                checks++; if (a_rsp_rdata !== exp_rdata) begin errors++; $display("FAIL %s rsp_rdata got=%h exp=%h", name, a_rsp_rdata, exp_rdata); end
                checks++; if (a_rsp_err !== stuck) begin errors++; $display("FAIL %s rsp_err got=%b exp=%b", name, a_rsp_err, stuck); end
            end else begin
                tick();
            end
        end
        a_probe = 1'b1;
`ifdef EBI_MASTER_WAIT_EN
        a_wait = 1'b0;
`endif
        tick();
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL %s rsp_pulse_len got=%b exp=0", name, a_rsp_valid); end
        checks++; if (a_rsp_rdata !== exp_rdata) begin errors++; $display("FAIL %s rdata_hold got=%h exp=%h", name, a_rsp_rdata, exp_rdata); end
    endtask

    task automatic test_write();
        txn_a("write", 1'b1, 19'h00032, 16'hA5A5, 16'h0000, 0, 1'b0);
    endtask

    task automatic test_read();
        txn_a("read", 1'b0, 19'h00038, 16'h0000, 16'h1234, 0, 1'b0);
        txn_a("write_zeroes", 1'b1, 19'h00039, 16'h3C3C, 16'h0000, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        b_rv        = 16'hC3C3;
        b_probe     = 1'b0;
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = 19'h00100;
        b_req_wdata = 16'h0F0F;
        tick();
        b_req_we    = 1'b0;
        b_req_addr  = 19'h00104;
        b_req_wdata = 16'hFFFF;
        for (int c = 1; c <= 6; c++) begin
            logic        e_cs, e_wr, e_rd, e_rsp;
            logic [15:0] e_bus;
            e_cs  = (c == 1) || (c == 2) || (c == 4) || (c == 5);
            e_wr  = (c == 2);
            e_rd  = (c == 5);
            e_rsp = (c == 3) || (c == 6);
            b_probe = (c > 2);
            #1;
            e_bus = (c <= 2) ? 16'h0F0F : ((c == 5) ? 16'hC3C3 : 16'h0000);
            checks++; if (b_cs !== e_cs) begin errors++; $display("FAIL b2b c%0d cs got=%b exp=%b", c, b_cs, e_cs); end
            checks++; if (b_wr !== e_wr) begin errors++; $display("FAIL b2b c%0d wr got=%b exp=%b", c, b_wr, e_wr); end
            checks++; if (b_rd !== e_rd) begin errors++; $display("FAIL b2b c%0d rd got=%b exp=%b", c, b_rd, e_rd); end
            checks++; if (b_rsp_valid !== e_rsp) begin errors++; $display("FAIL b2b c%0d rsp_valid got=%b exp=%b", c, b_rsp_valid, e_rsp); end
            checks++; if (b_req_ready !== e_rsp) begin errors++; $display("FAIL b2b c%0d req_ready got=%b exp=%b", c, b_req_ready, e_rsp); end
            checks++; if (b_data !== e_bus) begin errors++; $display("FAIL b2b c%0d bus got=%h exp=%h", c, b_data, e_bus); end
            if (c == 2) begin
                checks++; if (b_addr !== 19'h00100) begin errors++; $display("FAIL b2b wr_addr got=%h exp=00100", b_addr); end
            end
            if (c == 5) begin
                checks++; if (b_addr !== 19'h00104) begin errors++; $display("FAIL b2b rd_addr got=%h exp=00104", b_addr); end
            end
            if (c == 3) begin
                checks++; if (b_rsp_rdata !== 16'h0000) begin errors++; $display("FAIL b2b wr_rdata got=%h exp=0000", b_rsp_rdata); end
            end
            if (c == 6) begin
                checks++; if (b_rsp_rdata !== 16'hC3C3) begin errors++; $display("FAIL b2b rd_rdata got=%h exp=c3c3", b_rsp_rdata); end
            end
            if (c == 4) b_req_valid = 1'b0;
            if (c < 6) tick();
        end
        tick();
    endtask

    task automatic test_short_write();
        b_probe     = 1'b0;
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = 19'h7FFFF;
        b_req_wdata = 16'h8001;
        tick();
        b_req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            b_probe = (c == 3);
            #1;
            checks++; if (b_cs !== (c <= 2)) begin errors++; $display("FAIL short c%0d cs got=%b exp=%b", c, b_cs, c <= 2); end
            checks++; if (b_wr !== (c == 2)) begin errors++; $display("FAIL short c%0d wr got=%b exp=%b", c, b_wr, c == 2); end
            checks++; if (b_rsp_valid !== (c == 3)) begin errors++; $display("FAIL short c%0d rsp_valid got=%b exp=%b", c, b_rsp_valid, c == 3); end
            if (c <= 2) begin
                checks++; if (b_data !== 16'h8001) begin errors++; $display("FAIL short c%0d bus got=%h exp=8001", c, b_data); end
                checks++; if (b_addr !== 19'h7FFFF) begin errors++; $display("FAIL short c%0d addr got=%h exp=7ffff", c, b_addr); end
            end else begin
                checks++; if (b_rsp_rdata !== 16'h0000) begin errors++; $display("FAIL short rdata got=%h exp=0000", b_rsp_rdata); end
                checks++; if (b_data !== 16'h0000) begin errors++; $display("FAIL short released got=%h exp=0000", b_data); end
            end
            if (c < 3) tick();
        end
        b_probe = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        a_probe     = 1'b0;
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = 19'h00040;
        a_req_wdata = 16'h5AA5;
        tick();
        a_req_valid = 1'b0;
        tick();
        tick();
        tick();
        #1;
        checks++; if (a_wr !== 1'b1) begin errors++; $display("FAIL abort in_strobe wr got=%b exp=1", a_wr); end
        reset = 1'b1;
        tick();
        a_probe = 1'b1;
        #1;
        checks++; if ({a_cs, a_wr, a_rd} !== 3'b000) begin errors++; $display("FAIL abort strobes got=%b exp=000", {a_cs, a_wr, a_rd}); end
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL abort req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL abort rsp_valid got=%b exp=0", a_rsp_valid); end
        checks++; if (a_data !== 16'h0000) begin errors++; $display("FAIL abort bus got=%h exp=0000", a_data); end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({a_rsp_valid, a_cs} !== 2'b00) begin errors++; $display("FAIL abort idle%0d rsp_valid,cs got=%b exp=00", i, {a_rsp_valid, a_cs}); end
        end
        txn_a("read_after_abort", 1'b0, 19'h00044, 16'h0000, 16'hBEEF, 0, 1'b0);
    endtask

`ifdef EBI_MASTER_WAIT_EN
    task automatic test_wait();
        txn_a("wait2", 1'b0, 19'h00050, 16'h0000, 16'h7E57, 2, 1'b0);
        txn_a("wait_timeout", 1'b0, 19'h00051, 16'h0000, 16'h7E58, 0, 1'b1);
        txn_a("write_after_timeout", 1'b1, 19'h00052, 16'h6006, 16'h0000, 0, 1'b0);
    endtask
`endif

    initial begin
        reset       = 1'b1;
        a_req_valid = 1'b0;
        a_req_we    = 1'b0;
        a_req_addr  = '0;
        a_req_wdata = '0;
        a_rv        = '0;
        a_probe     = 1'b1;
        b_req_valid = 1'b0;
        b_req_we    = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        b_rv        = '0;
        b_probe     = 1'b1;
`ifdef EBI_MASTER_WAIT_EN
        a_wait      = 1'b0;
`endif
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_short_write();
        test_abort();
`ifdef EBI_MASTER_WAIT_EN
        test_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
